id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter CNT_W, default 16, width of the performance counters.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush_i  input  1  pipeline flush (exception/redirect) from a later stage.
REQ-005 ex_stall_i  input  1  EXE cannot accept a new instruction this cycle (multicycle op busy).
REQ-006 fwd_stall_i  input  1  load-use stall from the operand forwarding unit.
REQ-007 id_valid_i  input  1  decode stage holds a valid instruction.
REQ-008 id_pc_i  input  32  PC of the decoding instruction.
REQ-009 id_decoded_i  input  decoded_instr_t  decoded control fields, including register write address and load flag.
REQ-010 id_rs_data_i, id_rt_data_i  input  32 each  forwarded operand values.
REQ-011 id_ready_o  output  1  decode may advance; IF/ID register updates when high.
REQ-012 pipe_id_o  output  pipe_id_t  registered ID/EX payload: valid, pc, decoded, rs_data, rt_data.
REQ-013 bubble_cnt_o  output  CNT_W  bubbles inserted due to fwd_stall_i.
REQ-014 hold_cnt_o  output  CNT_W  cycles held due to ex_stall_i.

Function
REQ-015 The block SHALL resolve control each cycle with priority flush_i > ex_stall_i > fwd_stall_i > normal advance.
REQ-016 FLUSH: next pipe_id_o SHALL be a bubble; id_ready_o SHALL be 1.
REQ-017 HOLD (ex_stall_i, no flush): pipe_id_o SHALL keep its value unchanged; id_ready_o SHALL be 0; hold_cnt_o SHALL increment.
REQ-018 BUBBLE (fwd_stall_i, no flush, no ex_stall_i): next pipe_id_o SHALL be a bubble; id_ready_o SHALL be 0; bubble_cnt_o SHALL increment when id_valid_i is 1.
REQ-019 ADVANCE (none asserted): pipe_id_o SHALL load {id_valid_i, id_pc_i, id_decoded_i, id_rs_data_i, id_rt_data_i}; id_ready_o SHALL be 1.
REQ-020 A loaded payload with id_valid_i=0 SHALL be a bubble, not a copy of inputs.
REQ-021 Bubble: valid=0, pc=0, operands=0, decoded fields at NOP encoding with register write enable 0, write address 0 and load/dcache read flag 0, so forwarding never matches a bubble.
REQ-022 id_ready_o SHALL be combinational from flush_i, ex_stall_i, fwd_stall_i only; no dependence on id_valid_i.
REQ-023 Latency: an instruction presented with id_ready_o=1 and no flush SHALL appear on pipe_id_o exactly one cycle later.
REQ-024 During BUBBLE the decode stage re-presents the same instruction; the block SHALL capture the operand values present in the first ADVANCE cycle, never stale values from stall cycles.
REQ-025 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 flush_i with ex_stall_i SHALL flush (payload becomes bubble) and SHALL NOT increment hold_cnt_o.
REQ-027 ex_stall_i with fwd_stall_i SHALL hold and SHALL NOT increment bubble_cnt_o.

Reset
REQ-028 On rst_n low, asynchronously: pipe_id_o = bubble (per REQ-021), bubble_cnt_o=0, hold_cnt_o=0.
REQ-029 id_ready_o during reset follows REQ-022 from its inputs.
REQ-030 Reset asserted mid-HOLD SHALL discard the held instruction; first edge after release behaves per REQ-015.

Verification
REQ-031 Advance: id_valid_i=1, pc=0x00400010, rs=0x11, rt=0x22, no stalls -> next cycle pipe_id_o.valid=1, pc=0x00400010, rs_data=0x11, rt_data=0x22; id_ready_o=1.
REQ-032 Load-use: fwd_stall_i=1 for 1 cycle with valid instr, then 0 with rs updated 0x11->0xABCD -> bubble (valid=0, we=0, read=0) one cycle, then payload with rs_data=0xABCD; bubble_cnt_o=1.
REQ-033 EXE hold: ex_stall_i=1 for 3 cycles with pipe_id_o.pc=0x00400020 -> pc stays 0x00400020, id_ready_o=0 for 3 cycles, hold_cnt_o=3.
REQ-034 Flush priority: flush_i=1, ex_stall_i=1, fwd_stall_i=1 -> next pipe_id_o.valid=0, id_ready_o=1, both counters unchanged.
REQ-035 Saturation: CNT_W=4, 20 consecutive valid bubble cycles -> bubble_cnt_o=15 and stays 15.
REQ-036 Async reset: rst_n low mid-HOLD between edges -> pipe_id_o.valid=0 and counters 0 immediately, before next clk edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: payload capture with flush/hold/bubble control and
// saturating stall counters. Shared payload types live in id_ex_pkg below.
package id_ex_pkg;

  typedef struct packed {
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] wr_addr;
    logic       reg_we;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
  } decoded_instr_t;

  typedef struct packed {
    logic           valid;
    logic [31:0]    pc;
    decoded_instr_t decoded;
    logic [31:0]    rs_data;
    logic [31:0]    rt_data;
  } pipe_id_t;

  // All-zero decode is the NOP (sll $0,$0,0): no write, no load, address 0
  localparam decoded_instr_t NOP_DEC = '0;
  localparam pipe_id_t BUBBLE = '{valid: 1'b0, pc: 32'h0, decoded: NOP_DEC,
                                  rs_data: 32'h0, rt_data: 32'h0};

endpackage

module id_ex_reg
  import id_ex_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             ex_stall_i,
  input  logic             fwd_stall_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_pc_i,
  input  decoded_instr_t   id_decoded_i,
  input  logic [31:0]      id_rs_data_i,
  input  logic [31:0]      id_rt_data_i,
  output logic             id_ready_o,
  output pipe_id_t         pipe_id_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] hold_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  pipe_id_t         pipe_p1;
  logic [CNT_W-1:0] bubble_cnt_p1;
  logic [CNT_W-1:0] hold_cnt_p1;

  // Flush always lets decode move on; either stall blocks it
  assign id_ready_o = flush_i | ~(ex_stall_i | fwd_stall_i);

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_p1       <= BUBBLE;
      bubble_cnt_p1 <= '0;
      hold_cnt_p1   <= '0;
    end else if (flush_i) begin
      pipe_p1 <= BUBBLE;
    end else if (ex_stall_i) begin
      hold_cnt_p1 <= sat_inc(hold_cnt_p1);
    end else if (fwd_stall_i) begin
      pipe_p1 <= BUBBLE;
      if (id_valid_i)
        bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else if (id_valid_i) begin
      pipe_p1 <= '{valid: 1'b1, pc: id_pc_i, decoded: id_decoded_i,
                   rs_data: id_rs_data_i, rt_data: id_rt_data_i};
    end else begin
      pipe_p1 <= BUBBLE;
    end
  end

  assign pipe_id_o    = pipe_p1;
  assign bubble_cnt_o = bubble_cnt_p1;
  assign hold_cnt_o   = hold_cnt_p1;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, hand sequences for reset and
// saturation, then randomized traffic against a reference model.
module tb_id_ex_reg;
  import id_ex_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush_i, ex_stall_i, fwd_stall_i, id_valid_i;
  logic [31:0]    id_pc_i, id_rs_data_i, id_rt_data_i;
  decoded_instr_t id_decoded_i;
  logic           id_ready_o, ready4;
  pipe_id_t       pipe_id_o, pipe4;
  logic [15:0]    bubble_cnt_o, hold_cnt_o;
  logic [3:0]     bcnt4, hcnt4;

  always #5 clk = ~clk;

  id_ex_reg #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .fwd_stall_i(fwd_stall_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_decoded_i(id_decoded_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_ready_o(id_ready_o), .pipe_id_o(pipe_id_o),
    .bubble_cnt_o(bubble_cnt_o), .hold_cnt_o(hold_cnt_o));

  id_ex_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .fwd_stall_i(fwd_stall_i), .id_valid_i(id_valid_i), .id_pc_i(id_pc_i),
    .id_decoded_i(id_decoded_i), .id_rs_data_i(id_rs_data_i),
    .id_rt_data_i(id_rt_data_i), .id_ready_o(ready4), .pipe_id_o(pipe4),
    .bubble_cnt_o(bcnt4), .hold_cnt_o(hcnt4));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fl, input logic ex, input logic fw, input logic v,
                       input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt,
                       input decoded_instr_t d);
    flush_i = fl; ex_stall_i = ex; fwd_stall_i = fw; id_valid_i = v;
    id_pc_i = pc; id_rs_data_i = rs; id_rt_data_i = rt; id_decoded_i = d;
  endtask

  typedef struct {
    logic        fl, ex, fw, v;
    logic [31:0] pc, rs, rt;
    logic        e_ready, e_valid;
    logic [31:0] e_pc, e_rs;
    int          e_b, e_h;
  } vec_t;

  function automatic vec_t mk(logic fl, logic ex, logic fw, logic v,
                              logic [31:0] pc, logic [31:0] rs, logic [31:0] rt,
                              logic er, logic ev, logic [31:0] epc, logic [31:0] ers,
                              int eb, int eh);
    vec_t r;
    r.fl = fl; r.ex = ex; r.fw = fw; r.v = v; r.pc = pc; r.rs = rs; r.rt = rt;
    r.e_ready = er; r.e_valid = ev; r.e_pc = epc; r.e_rs = ers; r.e_b = eb; r.e_h = eh;
    return r;
  endfunction

  // Reference model: what the ID/EX register should hold, counts kept unbounded
  pipe_id_t exp_pipe;
  int       exp_b, exp_h;

  function automatic int sat(int v, int max);
    return (v > max) ? max : v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      exp_pipe = BUBBLE; exp_b = 0; exp_h = 0;
    end else if (flush_i) begin
      exp_pipe = BUBBLE;
    end else if (ex_stall_i) begin
      exp_h = exp_h + 1;
    end else if (fwd_stall_i) begin
      exp_pipe = BUBBLE;
      if (id_valid_i) exp_b = exp_b + 1;
    end else begin
      exp_pipe = BUBBLE;
      if (id_valid_i) begin
        exp_pipe.valid   = 1'b1;
        exp_pipe.pc      = id_pc_i;
        exp_pipe.decoded = id_decoded_i;
        exp_pipe.rs_data = id_rs_data_i;
        exp_pipe.rt_data = id_rt_data_i;
      end
    end
  endtask

  task automatic chk_model(input string tag);
    logic exp_ready;
    exp_ready = flush_i | !(ex_stall_i | fwd_stall_i);
    chk({tag, "_ready"}, 128'(id_ready_o), 128'(exp_ready));
    chk({tag, "_pipe"}, 128'(pipe_id_o), 128'(exp_pipe));
    chk({tag, "_pipe4"}, 128'(pipe4), 128'(exp_pipe));
    chk({tag, "_bcnt"}, 128'(bubble_cnt_o), 128'(sat(exp_b, 65535)));
    chk({tag, "_hcnt"}, 128'(hold_cnt_o), 128'(sat(exp_h, 65535)));
    chk({tag, "_bcnt4"}, 128'(bcnt4), 128'(sat(exp_b, 15)));
    chk({tag, "_hcnt4"}, 128'(hcnt4), 128'(sat(exp_h, 15)));
  endtask

  vec_t           tbl[10];
  decoded_instr_t dec_c;
  decoded_instr_t exp_dec;

  initial begin
    dec_c = '{opcode: 6'h23, funct: 6'h00, wr_addr: 5'd5, reg_we: 1'b1,
              mem_read: 1'b1, mem_write: 1'b0, alu_op: 4'h2};
    //          fl ex fw v  pc            rs         rt       rdy vld e_pc          e_rs     b  h
    tbl[0] = mk(0, 0, 0, 1, 32'h00400010, 32'h11,    32'h22, 1, 1, 32'h00400010, 32'h11,  0, 0);
    tbl[1] = mk(0, 0, 1, 1, 32'h00400014, 32'h11,    32'h33, 0, 0, 32'h0,        32'h0,   1, 0);
    tbl[2] = mk(0, 0, 0, 1, 32'h00400014, 32'hABCD,  32'h33, 1, 1, 32'h00400014, 32'hABCD,1, 0);
    tbl[3] = mk(0, 0, 0, 1, 32'h00400020, 32'h5,     32'h44, 1, 1, 32'h00400020, 32'h5,   1, 0);
    tbl[4] = mk(0, 1, 0, 1, 32'h00400024, 32'h6,     32'h55, 0, 1, 32'h00400020, 32'h5,   1, 1);
    tbl[5] = mk(0, 1, 0, 1, 32'h00400024, 32'h6,     32'h55, 0, 1, 32'h00400020, 32'h5,   1, 2);
    tbl[6] = mk(0, 1, 0, 1, 32'h00400024, 32'h6,     32'h55, 0, 1, 32'h00400020, 32'h5,   1, 3);
    tbl[7] = mk(1, 1, 1, 1, 32'h00400028, 32'h7,     32'h66, 1, 0, 32'h0,        32'h0,   1, 3);
    tbl[8] = mk(0, 0, 0, 0, 32'h00001234, 32'h99,    32'h77, 1, 0, 32'h0,        32'h0,   1, 3);
    tbl[9] = mk(0, 1, 1, 1, 32'h00400030, 32'h8,     32'h88, 0, 0, 32'h0,        32'h0,   1, 4);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, '0);
    #12;
    chk("reset_pipe", 128'(pipe_id_o), 128'(BUBBLE));
    chk("reset_bcnt", 128'(bubble_cnt_o), 128'd0);
    chk("reset_hcnt", 128'(hold_cnt_o), 128'd0);
    chk("reset_ready", 128'(id_ready_o), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].ex, tbl[i].fw, tbl[i].v, tbl[i].pc, tbl[i].rs, tbl[i].rt, dec_c);
      #1;
      chk($sformatf("v%0d_ready", i), 128'(id_ready_o), 128'(tbl[i].e_ready));
      @(posedge clk);
      #1;
      exp_dec = tbl[i].e_valid ? dec_c : NOP_DEC;
      chk($sformatf("v%0d_valid", i), 128'(pipe_id_o.valid), 128'(tbl[i].e_valid));
      chk($sformatf("v%0d_pc", i), 128'(pipe_id_o.pc), 128'(tbl[i].e_pc));
      chk($sformatf("v%0d_rs", i), 128'(pipe_id_o.rs_data), 128'(tbl[i].e_rs));
      chk($sformatf("v%0d_dec", i), 128'(pipe_id_o.decoded), 128'(exp_dec));
      chk($sformatf("v%0d_bcnt", i), 128'(bubble_cnt_o), 128'(tbl[i].e_b));
      chk($sformatf("v%0d_hcnt", i), 128'(hold_cnt_o), 128'(tbl[i].e_h));
    end

    // Async reset in the middle of a hold, checked before the next edge
    @(negedge clk);
    drive(0, 0, 0, 1, 32'h00400040, 32'h9, 32'h99, dec_c);
    @(negedge clk);
    drive(0, 1, 0, 1, 32'h00400044, 32'hA, 32'hAA, dec_c);
    @(posedge clk);
    #1;
    chk("hold_pc", 128'(pipe_id_o.pc), 128'h00400040);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 128'(pipe_id_o.valid), 128'd0);
    chk("async_pipe", 128'(pipe_id_o), 128'(BUBBLE));
    chk("async_bcnt", 128'(bubble_cnt_o), 128'd0);
    chk("async_hcnt", 128'(hold_cnt_o), 128'd0);
    chk("async_ready", 128'(id_ready_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_hcnt", 128'(hold_cnt_o), 128'd1);
    chk("post_rst_valid", 128'(pipe_id_o.valid), 128'd0);

    // Back-to-back valid bubbles: narrow counter must stick at 15
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      drive(0, 0, 1, 1, 32'h00400050, 32'hB, 32'hBB, dec_c);
      @(posedge clk);
      #1;
      chk($sformatf("sat4_%0d", i), 128'(bcnt4), 128'(sat(i, 15)));
      chk($sformatf("sat16_%0d", i), 128'(bubble_cnt_o), 128'(i));
    end

    exp_pipe = BUBBLE; exp_b = 20; exp_h = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      drive($urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(3) != 0, $urandom, $urandom, $urandom, decoded_instr_t'($urandom));
      if ($urandom_range(63) == 0) begin
        #2;
        rst_n = 1'b0;
        exp_pipe = BUBBLE; exp_b = 0; exp_h = 0;
        #1;
        chk_model($sformatf("rnd%0d_rst", c));
      end else begin
        #1;
        chk($sformatf("rnd%0d_ready", c), 128'(id_ready_o),
            128'(flush_i | !(ex_stall_i | fwd_stall_i)));
      end
      @(posedge clk);
      model_edge();
      #1;
      chk_model($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
